seq_detector_multi: RTL

SEQ_DETECTOR_MULTI -- requirements
Module: seq_detector_multi

---
 rtl/seq_det_pkg.sv | 25 ++
 rtl/seq_match_lane.sv | 22 ++
 rtl/seq_detector_multi.sv | 94 +++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults, legal parameter ranges and mode encodings for the multi-pattern detector.
// No logic: constants and types only.
// Not applicable to flow control.
package seq_det_pkg;

    localparam int LEN_DEF   = 3;
    localparam int NPAT_DEF  = 2;
    localparam int CNT_W_DEF = 8;

    localparam int LEN_MIN  = 2;
    localparam int LEN_MAX  = 8;
    localparam int NPAT_MIN = 1;
    localparam int NPAT_MAX = 4;

    typedef enum logic {
        NOVL = 1'b0,
        OVL  = 1'b1
    } ovl_mode_t;

    typedef enum logic {
        PULSE = 1'b0,
        TOG   = 1'b1
    } tog_mode_t;

endpackage

// File: rtl/seq_match_lane.sv
// One pattern comparator: history vs. pattern slice, qualified by enable and full window.
// Latency: combinational; the caller registers the result.
// Backpressure: none, evaluated every cycle on the post-shift view.
module seq_match_lane
    import seq_det_pkg::*;
#(
    parameter int LEN    = LEN_DEF,
    parameter int FILL_W = 2
) (
    input  logic [LEN-1:0]    hist,
    input  logic [FILL_W-1:0] fill,
    input  logic [LEN-1:0]    pat,
    input  logic              en,
    output logic              match
);

    logic full;

    assign full  = (fill == FILL_W'(LEN));
    assign match = en && full && (hist == pat);

endmodule

// File: rtl/seq_detector_multi.sv
// Serial multi-pattern detector with per-pattern hit flags, aggregate f and saturating event count.
// Latency: hit/f/hit_cnt update on the edge that accepts the matching sample (Moore, one-cycle pulse).
// Backpressure: none; samples are taken only when i_vld is high, otherwise state holds.
module seq_detector_multi
    import seq_det_pkg::*;
#(
    parameter int LEN   = LEN_DEF,
    parameter int NPAT  = NPAT_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                i,
    input  logic                i_vld,
    input  logic [NPAT*LEN-1:0] pat,
    input  logic [NPAT-1:0]     pat_en,
    input  logic                mode_ovl,
    input  logic                mode_tog,
    output logic [NPAT-1:0]     hit,
    output logic                f,
    output logic [CNT_W-1:0]    hit_cnt
);

    localparam int FILL_W = $clog2(LEN + 1);

    if (LEN < LEN_MIN || LEN > LEN_MAX) begin : g_len_chk
        $error("seq_detector_multi: LEN out of range");
    end
    if (NPAT < NPAT_MIN || NPAT > NPAT_MAX) begin : g_npat_chk
        $error("seq_detector_multi: NPAT out of range");
    end

    logic [LEN-1:0]    hist;
    logic [LEN-1:0]    hist_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [NPAT-1:0]   match;
    logic              evt;

    // Lanes look at the post-shift window so a match reflects the sample being accepted.
    assign hist_nxt = {hist[LEN-2:0], i};
    assign fill_nxt = (fill == FILL_W'(LEN)) ? fill : fill + FILL_W'(1);

    for (genvar k = 0; k < NPAT; k++) begin : g_lane
        seq_match_lane #(
            .LEN    (LEN),
            .FILL_W (FILL_W)
        ) u_lane (
            .hist  (hist_nxt),
            .fill  (fill_nxt),
            .pat   (pat[k*LEN +: LEN]),
            .en    (pat_en[k]),
            .match (match[k])
        );
    end

    assign evt = i_vld && (|match);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist    <= '0;
            fill    <= '0;
            hit     <= '0;
            f       <= 1'b0;
            hit_cnt <= '0;
        end else if (clr) begin
            hist    <= '0;
            fill    <= '0;
            hit     <= '0;
            f       <= 1'b0;
            hit_cnt <= '0;
        end else begin
            hit <= i_vld ? match : '0;

            if (i_vld) begin
                hist <= hist_nxt;
                fill <= (evt && (mode_ovl == NOVL)) ? '0 : fill_nxt;
            end

            // Toggle mode keeps its level between events; pulse mode follows the event.
            if (mode_tog == TOG) begin
                f <= f ^ evt;
            end else begin
                f <= evt;
            end

            if (evt && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
        end
    end

endmodule
